psram_responder: RTL and testbench
==================================

PSRAM_RESPONDER -- requirements
Module: psram_responder

Interface
REQ-001 SHALL provide parameter ADDR_BITS, default 8, meaning the number of low address bits decoded by the internal storage (depth 2^ADDR_BITS bytes).
REQ-002 SHALL provide parameter ID_BYTE0, default 8'h0D, meaning the first byte returned by Read-ID.
REQ-003 SHALL provide parameter ID_BYTE1, default 8'h5D, meaning the second byte returned by Read-ID.
REQ-004 clkSys  input  1  system clock; the only clock of the block.
REQ-005 reset  input  1  synchronous, active-low reset sampled on rising clkSys.
REQ-006 i_psram_cs  input  1  chip select, active low, asynchronous to the block.
REQ-007 i_psram_sclk  input  1  serial clock from the memory controller, asynchronous to the block.
REQ-008 i_psram_si  input  1  serial data in (data0 line), MSB first.
REQ-009 o_psram_so  output  1  serial data out (data1 line), MSB first.
REQ-010 o_psram_so_oe  output  1  high while the block drives o_psram_so.
REQ-011 o_lastCmd  output  8  last complete command byte received.
REQ-012 o_active  output  1  high while a transaction is in progress (state other than IDLE).

Function
REQ-013 i_psram_cs, i_psram_sclk, i_psram_si SHALL each pass a 2-flop synchronizer; sclk edges are detected from the synchronized value (1 extra flop).
REQ-014 Legal input: sclk high and low phases each at least 4 clkSys cycles; CS low at least 4 clkSys cycles before the first sclk rise.
REQ-015 SI SHALL be sampled on each detected sclk rising edge; SO SHALL change only on detected sclk falling edges, valid no later than 3 clkSys cycles after the sclk fall at the pins.
REQ-016 States: IDLE, CMD, ADDR, WDATA, RDATA, RDID, IGNORE; 3-bit bit counter, 2-bit byte counter.
REQ-017 IDLE -> CMD on synchronized CS falling; bit/byte counters cleared.
REQ-018 CMD: after 8 rising edges latch byte into o_lastCmd; 8'h02 or 8'h03 -> ADDR; 8'h9F -> ADDR (address bytes ignored, then RDID); any other value -> IGNORE.
REQ-019 ADDR: shift in 24 address bits MSB first; the low ADDR_BITS form the working pointer; then 8'h02 -> WDATA, 8'h03 -> RDATA, 8'h9F -> RDID.
REQ-020 WDATA: each full 8-bit byte SHALL be written to storage at pointer in the clkSys cycle after its 8th rising edge; pointer then increments.
REQ-021 RDATA: the byte at pointer SHALL be loaded into the output shifter on the sclk fall following the last address bit (no wait cycles); its MSB appears on that fall, remaining bits on subsequent falls; after each 8th bit pointer increments and the next byte loads.
REQ-022 Pointer arithmetic SHALL be modulo 2^ADDR_BITS; burst past the top wraps to 0.
REQ-023 RDID: output ID_BYTE0 then ID_BYTE1, then repeat ID_BYTE0, ID_BYTE1 while CS stays low.
REQ-024 IGNORE: no storage access, o_psram_so_oe low, remain until CS high.
REQ-025 o_psram_so_oe SHALL be high only in RDATA and RDID; o_psram_so SHALL be 0 whenever o_psram_so_oe is low.
REQ-026 Synchronized CS rising from any state SHALL return to IDLE within 1 clkSys cycle; a partially received data byte is discarded and storage is unchanged.
REQ-027 CS rising coincident with the 8th sclk rise of a write byte: the byte SHALL be written (edge detect precedes CS abort).
REQ-028 o_active SHALL be low exactly in IDLE.

Reset
REQ-029 While reset is low at a clkSys rise: state IDLE, counters 0, pointer 0, o_psram_so=0, o_psram_so_oe=0, o_lastCmd=8'h00, o_active=0, synchronizer flops set to CS=1, sclk=0.
REQ-030 Storage contents SHALL NOT be cleared by reset; reset asserted mid-transaction aborts it with no further storage write.
REQ-031 After reset release, a transaction SHALL only start from a fresh CS falling edge.

Verification
REQ-032 Write 02 00FFFC AA, CS high; read 03 00FFFC, 8 clocks -> SO returns 8'hAA, o_lastCmd=8'h03.
REQ-033 Burst write 02 0000FE 11 22 33; read 03 0000FE 3 bytes -> 11 22 33 (address FF then wraps to 00).
REQ-034 Command 9F, 24 address clocks, 32 data clocks -> 0D 5D 0D 5D; o_psram_so_oe high only during data phase.
REQ-035 Command 8'h55 followed by 40 clocks with SI toggling -> o_psram_so_oe stays 0, storage unchanged, o_lastCmd=8'h55.
REQ-036 Write 02 000010 with CS raised after 5 data bits -> readback of 000010 returns prior value; o_active low within 4 clkSys cycles of CS rise.
REQ-037 Reset pulsed low during RDATA -> o_psram_so_oe=0, o_active=0 next cycle; subsequent read returns previously written data.

Source files
------------

// File: rtl/psram_responder.sv
// psram_responder: SPI-style PSRAM target model. Serial pins arrive asynchronously
// and are synchronized into the clkSys domain; a small FSM decodes write (02),
// read (03) and read-ID (9F) commands against a 2^ADDR_BITS byte storage array.
module psram_responder #(
    parameter int          ADDR_BITS = 8,
    parameter logic [7:0]  ID_BYTE0  = 8'h0D,
    parameter logic [7:0]  ID_BYTE1  = 8'h5D
) (
    input  logic       clkSys,
    input  logic       reset,
    input  logic       i_psram_cs,
    input  logic       i_psram_sclk,
    input  logic       i_psram_si,
    output logic       o_psram_so,
    output logic       o_psram_so_oe,
    output logic [7:0] o_lastCmd,
    output logic       o_active
);

    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CMD    = 3'd1;
    localparam logic [2:0] ADDR   = 3'd2;
    localparam logic [2:0] WDATA  = 3'd3;
    localparam logic [2:0] RDATA  = 3'd4;
    localparam logic [2:0] RDID   = 3'd5;
    localparam logic [2:0] IGNORE = 3'd6;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_RDID  = 8'h9F;

    localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    // Synchronizer and edge-detect flops
    logic csMeta, csSync, csPrev;
    logic sclkMeta, sclkSync, sclkPrev;
    logic siMeta, siSync;

    // Protocol state
    logic [2:0]           state;
    logic [2:0]           bitCnt;
    logic [1:0]           byteCnt;
    logic [7:0]           shiftIn;
    logic [7:0]           shiftOut;
    logic                 soReg;
    logic [ADDR_BITS-1:0] ptr;
    logic [7:0]           lastCmd;
    logic                 writePending;
    logic [7:0]           writeData;

    logic [7:0] mem [DEPTH];

    logic                 sclkRise;
    logic                 sclkFall;
    logic                 csFall;
    logic [7:0]           inByte;
    logic [ADDR_BITS:0]   ptrShiftWide;
    logic [7:0]           loadByte;

    assign sclkRise     = sclkSync & ~sclkPrev;
    assign sclkFall     = ~sclkSync & sclkPrev;
    assign csFall       = csPrev & ~csSync;
    assign inByte       = {shiftIn[6:0], siSync};
    assign ptrShiftWide = {ptr, siSync};

    // Pick the next byte for the output shifter: ID bytes in RDID, storage otherwise
    always_comb begin
        // NOTE: a default before any conditional assignment keeps this purely combinational (no latch).
        loadByte = mem[ptr];
        if (state == RDID) begin
            loadByte = byteCnt[0] ? ID_BYTE1 : ID_BYTE0;
        end
    end

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge clkSys) begin
        if (!reset) begin
            csMeta   <= 1'b1;
            csSync   <= 1'b1;
            csPrev   <= 1'b1;
            sclkMeta <= 1'b0;
            sclkSync <= 1'b0;
            sclkPrev <= 1'b0;
            siMeta   <= 1'b0;
            siSync   <= 1'b0;
        end else begin
            csMeta   <= i_psram_cs;
            csSync   <= csMeta;
            csPrev   <= csSync;
            sclkMeta <= i_psram_sclk;
            sclkSync <= sclkMeta;
            sclkPrev <= sclkSync;
            siMeta   <= i_psram_si;
            siSync   <= siMeta;
        end
    end

    // Transaction FSM; the CS abort is applied last so a coincident 8th sclk rise still completes its byte
    always_ff @(posedge clkSys) begin
        if (!reset) begin
            state        <= IDLE;
            bitCnt       <= 3'd0;
            byteCnt      <= 2'd0;
            shiftIn      <= 8'h00;
            shiftOut     <= 8'h00;
            soReg        <= 1'b0;
            ptr          <= '0;
            lastCmd      <= 8'h00;
            writePending <= 1'b0;
            writeData    <= 8'h00;
        end else begin
            if (writePending) begin
                writePending <= 1'b0;
                ptr          <= ptr + PTR_ONE;
            end

            case (state)
                IDLE: begin
                    if (csFall) begin
                        state   <= CMD;
                        bitCnt  <= 3'd0;
                        byteCnt <= 2'd0;
                    end
                end

                CMD: begin
                    if (sclkRise) begin
                        shiftIn <= inByte;
                        bitCnt  <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            lastCmd <= inByte;
                            if (inByte == CMD_WRITE || inByte == CMD_READ || inByte == CMD_RDID) begin
                                state <= ADDR;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                end

                ADDR: begin
                    if (sclkRise) begin
                        ptr    <= ptrShiftWide[ADDR_BITS-1:0];
                        bitCnt <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            if (byteCnt == 2'd2) begin
                                byteCnt <= 2'd0;
                                case (lastCmd)
                                    CMD_WRITE: state <= WDATA;
                                    CMD_READ:  state <= RDATA;
                                    default:   state <= RDID;
                                endcase
                            end else begin
                                byteCnt <= byteCnt + 2'd1;
                            end
                        end
                    end
                end

                WDATA: begin
                    if (sclkRise) begin
                        shiftIn <= inByte;
                        bitCnt  <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            writePending <= 1'b1;
                            writeData    <= inByte;
                        end
                    end
                end

                RDATA, RDID: begin
                    if (sclkFall) begin
                        bitCnt <= bitCnt + 3'd1;
                        if (bitCnt == 3'd0) begin
                            soReg    <= loadByte[7];
                            shiftOut <= {loadByte[6:0], 1'b0};
                        end else begin
                            soReg    <= shiftOut[7];
                            shiftOut <= {shiftOut[6:0], 1'b0};
                        end
                        if (bitCnt == 3'd7) begin
                            if (state == RDATA) begin
                                ptr <= ptr + PTR_ONE;
                            end else begin
                                byteCnt <= byteCnt + 2'd1;
                            end
                        end
                    end
                end

                IGNORE: begin
                    state <= IGNORE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            if (csSync && state != IDLE) begin
                state   <= IDLE;
                bitCnt  <= 3'd0;
                byteCnt <= 2'd0;
                soReg   <= 1'b0;
            end
        end
    end

    // Storage write port, one cycle after a completed write byte
    always_ff @(posedge clkSys) begin
        // NOTE: storage has no reset branch on purpose; only the write strobe is gated by reset.
        if (reset && writePending) begin
            mem[ptr] <= writeData;
        end
    end

    assign o_psram_so_oe = (state == RDATA) || (state == RDID);
    assign o_psram_so    = o_psram_so_oe & soReg;
    assign o_lastCmd     = lastCmd;
    assign o_active      = (state != IDLE);

endmodule

// File: tb/tb_psram_responder.sv
// tb_psram_responder: directed plus randomized serial transactions against a
// byte-array reference model of the PSRAM storage and ID sequence.
module tb_psram_responder;

    logic       clkSys = 1'b0;
    logic       reset;
    logic       psramCs;
    logic       psramSclk;
    logic       psramSi;
    logic       psramSo;
    logic       psramSoOe;
    logic [7:0] lastCmd;
    logic       active;

    always #5 clkSys = ~clkSys;

    psram_responder dut (
        .clkSys        (clkSys),
        .reset         (reset),
        .i_psram_cs    (psramCs),
        .i_psram_sclk  (psramSclk),
        .i_psram_si    (psramSi),
        .o_psram_so    (psramSo),
        .o_psram_so_oe (psramSoOe),
        .o_lastCmd     (lastCmd),
        .o_active      (active)
    );

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: plain byte array indexed modulo 256
    logic [7:0] refMem [256];

    logic [7:0] txQ [$];
    logic [7:0] rxQ [$];
    logic [7:0] oeQ [$];
    logic [7:0] ctlOe;
    logic       activeMid;
    logic       soLeak;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clkSys);
        #2;
    endtask

    // Shift nBits of tx MSB first; SO/OE are sampled late in each low phase
    task automatic xferBits(input logic [7:0] tx, input int nBits,
                            output logic [7:0] rx, output logic [7:0] oeBits);
        rx     = 8'h00;
        oeBits = 8'h00;
        for (int i = 7; i >= 8 - nBits; i--) begin
            psramSi = tx[i];
            waitCycles(5);
            rx[i]     = psramSo;
            oeBits[i] = psramSoOe;
            if (!psramSoOe && psramSo) soLeak = 1'b1;
            psramSclk = 1'b1;
            waitCycles(5);
            psramSclk = 1'b0;
        end
    endtask

    task automatic csLow();
        psramCs = 1'b0;
        waitCycles(6);
    endtask

    task automatic csHigh();
        waitCycles(5);
        psramCs = 1'b1;
        waitCycles(8);
    endtask

    task automatic doTxn(input logic [7:0] cmd, input logic [23:0] addr, input bit withAddr, input int nData);
        logic [7:0] rx;
        logic [7:0] oe;
        rxQ.delete();
        oeQ.delete();
        ctlOe = 8'h00;
        csLow();
        xferBits(cmd, 8, rx, oe);
        ctlOe |= oe;
        activeMid = active;
        if (withAddr) begin
            for (int b = 2; b >= 0; b--) begin
                xferBits(addr[b*8 +: 8], 8, rx, oe);
                ctlOe |= oe;
            end
        end
        for (int k = 0; k < nData; k++) begin
            xferBits((k < txQ.size()) ? txQ[k] : 8'h00, 8, rx, oe);
            rxQ.push_back(rx);
            oeQ.push_back(oe);
        end
        csHigh();
    endtask

    task automatic modelWrite(input logic [23:0] addr);
        foreach (txQ[k]) refMem[(int'(addr[7:0]) + k) % 256] = txQ[k];
    endtask

    task automatic checkRead(input string tag, input logic [23:0] addr, input int n);
        for (int k = 0; k < n; k++) begin
            check(tag, rxQ[k], refMem[(int'(addr[7:0]) + k) % 256]);
            check({tag, "_oe"}, oeQ[k], 8'hFF);
        end
        check({tag, "_ctl_oe"}, ctlOe, 8'h00);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  rx;
        logic [7:0]  oe;
        logic [7:0]  val;
        logic [23:0] addr;
        int          n;
        int          lat;

        reset = 1'b0; psramCs = 1'b1; psramSclk = 1'b0; psramSi = 1'b0; soLeak = 1'b0;
        waitCycles(4);
        check("rst_so", psramSo, 1'b0);
        check("rst_oe", psramSoOe, 1'b0);
        check("rst_active", active, 1'b0);
        check("rst_lastcmd", lastCmd, 8'h00);
        reset = 1'b1;
        waitCycles(4);
        check("idle_active", active, 1'b0);

        // Single write then read at 00FFFC
        txQ = '{8'hAA};
        doTxn(8'h02, 24'h00FFFC, 1'b1, 1);
        modelWrite(24'h00FFFC);
        check("wr_lastcmd", lastCmd, 8'h02);
        check("wr_active_mid", activeMid, 1'b1);
        txQ.delete();
        doTxn(8'h03, 24'h00FFFC, 1'b1, 1);
        checkRead("rd_fffc", 24'h00FFFC, 1);
        check("rd_lastcmd", lastCmd, 8'h03);
        check("rd_idle_after", active, 1'b0);

        // Burst across the top of storage
        txQ = '{8'h11, 8'h22, 8'h33};
        doTxn(8'h02, 24'h0000FE, 1'b1, 3);
        modelWrite(24'h0000FE);
        txQ.delete();
        doTxn(8'h03, 24'h0000FE, 1'b1, 3);
        checkRead("rd_wrap", 24'h0000FE, 3);

        // Read-ID repeats the two ID bytes
        txQ.delete();
        doTxn(8'h9F, 24'h000000, 1'b1, 4);
        for (int k = 0; k < 4; k++) begin
            check("rdid_byte", rxQ[k], (k % 2 == 0) ? 8'h0D : 8'h5D);
            check("rdid_oe", oeQ[k], 8'hFF);
        end
        check("rdid_ctl_oe", ctlOe, 8'h00);
        check("rdid_lastcmd", lastCmd, 8'h9F);

        // Unknown command: ignored, no drive, storage untouched
        txQ = '{8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55};
        doTxn(8'h55, 24'h000000, 1'b0, 5);
        for (int k = 0; k < 5; k++) check("ign_oe", oeQ[k], 8'h00);
        check("ign_ctl_oe", ctlOe, 8'h00);
        check("ign_lastcmd", lastCmd, 8'h55);
        check("ign_active_mid", activeMid, 1'b1);
        txQ.delete();
        doTxn(8'h03, 24'h0000FE, 1'b1, 3);
        checkRead("ign_unchanged", 24'h0000FE, 3);

        // Partial write byte aborted by CS rise
        txQ = '{8'hBB};
        doTxn(8'h02, 24'h000010, 1'b1, 1);
        modelWrite(24'h000010);
        csLow();
        xferBits(8'h02, 8, rx, oe);
        xferBits(8'h00, 8, rx, oe);
        xferBits(8'h00, 8, rx, oe);
        xferBits(8'h10, 8, rx, oe);
        xferBits(8'h5A, 5, rx, oe);
        waitCycles(2);
        psramCs = 1'b1;
        lat = 0;
        while (active && lat < 10) begin
            waitCycles(1);
            lat++;
        end
        check("abort_latency_le4", lat <= 4, 1'b1);
        waitCycles(8);
        txQ.delete();
        doTxn(8'h03, 24'h000010, 1'b1, 1);
        checkRead("abort_unchanged", 24'h000010, 1);

        // CS rise coincident with the 8th sclk rise still writes the byte
        val = 8'($urandom);
        csLow();
        xferBits(8'h02, 8, rx, oe);
        xferBits(8'h00, 8, rx, oe);
        xferBits(8'h00, 8, rx, oe);
        xferBits(8'h20, 8, rx, oe);
        xferBits(val, 7, rx, oe);
        psramSi = val[0];
        waitCycles(5);
        psramSclk = 1'b1;
        psramCs   = 1'b1;
        waitCycles(5);
        psramSclk = 1'b0;
        waitCycles(8);
        txQ = '{val};
        modelWrite(24'h000020);
        txQ.delete();
        doTxn(8'h03, 24'h000020, 1'b1, 1);
        checkRead("coincident_write", 24'h000020, 1);

        // Randomized bursts with random upper address bits
        for (int it = 0; it < 3; it++) begin
            addr = 24'($urandom);
            n    = $urandom_range(2, 6);
            txQ.delete();
            for (int k = 0; k < n; k++) txQ.push_back(8'($urandom));
            doTxn(8'h02, addr, 1'b1, n);
            modelWrite(addr);
            txQ.delete();
            doTxn(8'h03, addr, 1'b1, n);
            checkRead("rand_burst", addr, n);
        end

        // Reset pulse in the middle of a read
        txQ = '{8'hC3, 8'h3C};
        doTxn(8'h02, 24'h000030, 1'b1, 2);
        modelWrite(24'h000030);
        csLow();
        xferBits(8'h03, 8, rx, oe);
        xferBits(8'h00, 8, rx, oe);
        xferBits(8'h00, 8, rx, oe);
        xferBits(8'h30, 8, rx, oe);
        xferBits(8'h00, 3, rx, oe);
        check("pre_rst_oe", psramSoOe, 1'b1);
        reset = 1'b0;
        waitCycles(1);
        check("midrst_oe", psramSoOe, 1'b0);
        check("midrst_active", active, 1'b0);
        psramCs = 1'b1;
        waitCycles(3);
        reset = 1'b1;
        waitCycles(6);
        check("midrst_lastcmd", lastCmd, 8'h00);
        check("midrst_idle", active, 1'b0);
        txQ.delete();
        doTxn(8'h03, 24'h000030, 1'b1, 2);
        checkRead("post_rst_read", 24'h000030, 2);

        check("so_zero_when_off", soLeak, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
